// File: rtl/int_mult_seq.sv
// Iterative multiplier: full 2*DATA_WIDTH product, BITS_PER_CYCLE multiplier bits per clock.
// Optional signed mode is enabled by defining INT_MULT_SEQ_SIGNED_EN.
module int_mult_seq #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] m_plier,
  input  logic [DATA_WIDTH-1:0] m_cand,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned B     = BITS_PER_CYCLE;
  localparam int unsigned N     = W / B;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PP_W  = W + B;
  localparam int unsigned ACC_W = 2 * W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic               load_c, step_c, last_c;
  logic [W-1:0]       m_cand_r, m_plier_r;
  logic [W-1:0]       cand_mag_c, plier_mag_c;
  logic [CNT_W-1:0]   cnt, idx_c;
  logic [PP_W-1:0]    pp_c;
  logic [ACC_W-1:0]   acc, acc_sum_c, final_c, result_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)      state_nxt = BUSY;
      BUSY: if (cnt == '0)     state_nxt = DONE;
      DONE: if (out_ready)     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Datapath control strobes
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    case (state)
      IDLE: load_c = in_valid;
      BUSY: begin
        step_c = 1'b1;
        last_c = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Partial product placed at the weight of the current iteration
  assign pp_c      = PP_W'(m_cand_r) * PP_W'(m_plier_r[B-1:0]);
  assign idx_c     = CNT_W'(N - 1) - cnt;
  assign acc_sum_c = acc + (ACC_W'(pp_c) << (B * idx_c));

`ifdef INT_MULT_SEQ_SIGNED_EN
  logic neg_r;

  assign cand_mag_c  = (is_signed && m_cand[W-1])  ? W'(~m_cand + W'(1))  : m_cand;
  assign plier_mag_c = (is_signed && m_plier[W-1]) ? W'(~m_plier + W'(1)) : m_plier;
  assign final_c     = neg_r ? ACC_W'(~acc_sum_c + ACC_W'(1)) : acc_sum_c;

  // Sign of the product, captured with the operands
  always_ff @(posedge clk) begin
    if (rst)         neg_r <= 1'b0;
    else if (load_c) neg_r <= is_signed & (m_plier[W-1] ^ m_cand[W-1]);
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign cand_mag_c       = m_cand;
  assign plier_mag_c      = m_plier;
  assign final_c          = acc_sum_c;
`endif

  // Operand, accumulator, result and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cand_r  <= '0;
      m_plier_r <= '0;
      cnt       <= '0;
      acc       <= '0;
      result_r  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (load_c) begin
        m_cand_r  <= cand_mag_c;
        m_plier_r <= plier_mag_c;
        acc       <= '0;
        cnt       <= CNT_W'(N - 1);
      end else if (step_c) begin
        acc       <= acc_sum_c;
        m_plier_r <= m_plier_r >> B;
        cnt       <= cnt - CNT_W'(1);
        if (last_c) result_r <= final_c;
      end
    end
  end

  assign result_lo = result_r[W-1:0];
  assign result_hi = result_r[ACC_W-1:W];

endmodule
